mips_program_loader: RTL and testbench
======================================

MIPS_PROGRAM_LOADER -- requirements
Module: mips_program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0, giving the first byte address written after reset or start.
REQ-002 SHALL have parameter MEM_BYTES, default 4096, giving the instruction/data byte-memory size.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  field-level instruction offered.
REQ-007 in_ready  out  1  loader accepts fields this cycle.
REQ-008 in_opcode  in  6  MIPS-lite opcode, 0..17 valid.
REQ-009 in_rs / in_rt / in_rd  in  5 each  register fields.
REQ-010 in_imm  in  16  immediate or branch offset, two's complement.
REQ-011 start  in  1  one-cycle pulse; restarts loading from DONE.
REQ-012 mem_we  out  1  byte-write strobe.
REQ-013 mem_addr  out  12  byte address.
REQ-014 mem_wdata  out  8  byte data.
REQ-015 busy  out  1  high in WRITE.
REQ-016 done  out  1  high in DONE.
REQ-017 err_opcode  out  1  one-cycle pulse, opcode > 17 dropped.
REQ-018 err_full  out  1  sticky; memory overflow.
REQ-019 instr_count / branch_count  out  32 each  words written / BZ, BEQ, JR words written.

Function
REQ-020 SHALL implement the FSM IDLE -> WRITE -> IDLE, IDLE -> DONE, and DONE -> IDLE.
REQ-021 SHALL assert in_ready only in IDLE; a transfer occurs on in_valid && in_ready at a rising edge.
REQ-022 R-type (ADD, SUB, MUL, OR, AND, XOR) SHALL encode {op, rs, rt, rd, 11'b0}.
REQ-023 I-type (ADDI, SUBI, MULI, ORI, ANDI, XORI, LOAD, STORE) and BEQ SHALL encode {op, rs, rt, imm}.
REQ-024 BZ SHALL encode {op, rs, 5'b0, imm}.
REQ-025 JR SHALL encode {op, rs, 21'b0}.
REQ-026 HALT SHALL encode {op, 26'b0}.
REQ-027 Unused input fields SHALL be ignored, never propagated to the encoded word.
REQ-028 A transfer accepted at edge N SHALL drive mem_we=1 in cycles N+1..N+4, writing big-endian word[31:24], [23:16], [15:8], [7:0] to addr, addr+1, addr+2, addr+3.
REQ-029 After a transfer accepted at edge N, the FSM SHALL be back in IDLE at cycle N+5, or in DONE if the word was HALT.
REQ-030 mem_we SHALL be 0 outside WRITE.
REQ-031 The write address SHALL advance by 4 per word written.
REQ-032 instr_count SHALL increment by 1 when byte 3 is written; branch_count SHALL increment likewise for BZ, BEQ, JR.
REQ-033 An opcode > 17 SHALL be consumed with in_ready=1, pulse err_opcode in cycle N+1, write nothing, and leave address and counts unchanged.
REQ-034 If address + 4 > MEM_BYTES at acceptance, the loader SHALL write nothing, set err_full, and enter DONE.
REQ-035 start SHALL be honoured only in DONE: next cycle IDLE, address = BASE_ADDR, counts and err_full cleared; start in IDLE or WRITE SHALL be ignored.
REQ-036 in DONE, in_ready SHALL be 0 and in_valid SHALL be ignored.

Reset
REQ-037 On reset the loader SHALL enter IDLE with address = BASE_ADDR, mem_we = 0, busy = 0, done = 0, err_opcode = 0, err_full = 0, and both counts = 0.
REQ-038 reset SHALL take priority over start and in_valid.
REQ-039 reset mid-WRITE SHALL abandon the partial word with no further writes; bytes already written stay in memory.

Structure
REQ-040 Opcode constants (ADD = 0 .. HALT = 17), the FSM state enum, and an encode function returning the 32-bit word SHALL live in the shared MIPS package.
REQ-041 The block SHALL contain no sub-modules; the encode function is the only factored logic.

Verification
REQ-042 ADD rs=1 rt=2 rd=3, then reset mid-byte-1 -> bytes 00, 22 at addr 0, 1; no further mem_we; IDLE with address 0 in the cycle after reset.
REQ-043 ADD rs=1 rt=2 rd=3 -> word 0x00221800; bytes 00, 22, 18, 00 at addr 0..3; instr_count = 1.
REQ-044 ADDI rt=1 imm=5, then BEQ rs=1 rt=2 imm=-2 -> 0x04010005 at addr 0..3 and 0x3C22FFFE at addr 4..7; branch_count = 1.
REQ-045 HALT with in_rd=31 -> 0x44000000 written; done = 1; in_valid ignored; start -> IDLE at BASE_ADDR with counts 0.
REQ-046 opcode 20 -> err_opcode pulses once; no mem_we; next ADD lands at addr 0.
REQ-047 MEM_BYTES = 8: 2 words written, 3rd offered -> err_full = 1, DONE, no write to addr 8.

Source files
------------

// File: rtl/mips_program_loader_pkg.sv
// Shared MIPS-lite definitions: opcode values, loader FSM states and the word encoder.
package mips_program_loader_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_SUBI  = 6'd3;
    localparam logic [5:0] OP_MUL   = 6'd4;
    localparam logic [5:0] OP_MULI  = 6'd5;
    localparam logic [5:0] OP_OR    = 6'd6;
    localparam logic [5:0] OP_ORI   = 6'd7;
    localparam logic [5:0] OP_AND   = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd9;
    localparam logic [5:0] OP_XOR   = 6'd10;
    localparam logic [5:0] OP_XORI  = 6'd11;
    localparam logic [5:0] OP_LOAD  = 6'd12;
    localparam logic [5:0] OP_STORE = 6'd13;
    localparam logic [5:0] OP_BZ    = 6'd14;
    localparam logic [5:0] OP_BEQ   = 6'd15;
    localparam logic [5:0] OP_JR    = 6'd16;
    localparam logic [5:0] OP_HALT  = 6'd17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Fields an instruction format does not use are forced to zero.
    function automatic logic [31:0] encode(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [15:0] imm);
        logic [31:0] w;
        w = {op, 26'd0};
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR:
                w = {op, rs, rt, rd, 11'd0};
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI,
            OP_LOAD, OP_STORE, OP_BEQ:
                w = {op, rs, rt, imm};
            OP_BZ:   w = {op, rs, 5'd0, imm};
            OP_JR:   w = {op, rs, 21'd0};
            default: w = {op, 26'd0};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mips_program_loader_if.sv
// Instruction-field handshake plus byte-wide memory write port of the program loader.
interface mips_program_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport master (
        output in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_program_loader.sv
// Encodes MIPS-lite instruction fields and streams each word big-endian into byte memory.
// One word takes 4 write cycles; in_ready is held low while writing and after HALT/overflow.
module mips_program_loader
    import mips_program_loader_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int MEM_BYTES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_program_loader_if.slave   bus,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   err_opcode,
    output logic                   err_full,
    output logic [31:0]            instr_count,
    output logic [31:0]            branch_count
);

    state_e      state_q;
    state_e      state_d;
    logic [12:0] addr_q;
    logic [31:0] word_q;
    logic [1:0]  byte_q;
    logic        accept;
    logic        op_bad;
    logic        no_room;

    assign accept  = bus.in_valid && bus.in_ready;
    assign op_bad  = bus.in_opcode > OP_HALT;
    // 13-bit address can reach MEM_BYTES itself, so compare one bit wider.
    assign no_room = (14'(addr_q) + 14'd4) > 14'(MEM_BYTES);

    assign bus.mem_addr  = addr_q[11:0] + 12'(byte_q);
    assign bus.mem_wdata = word_q[{~byte_q, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        bus.mem_we   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (accept && !op_bad) begin
                    state_d = no_room ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy       = 1'b1;
                bus.mem_we = 1'b1;
                if (byte_q == 2'd3) begin
                    state_d = (word_q[31:26] == OP_HALT) ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= 13'(BASE_ADDR);
            word_q       <= 32'd0;
            byte_q       <= 2'd0;
            err_opcode   <= 1'b0;
            err_full     <= 1'b0;
            instr_count  <= 32'd0;
            branch_count <= 32'd0;
        end else begin
            state_q    <= state_d;
            err_opcode <= accept && op_bad;
            case (state_q)
                ST_IDLE: begin
                    if (accept && !op_bad) begin
                        if (no_room) begin
                            err_full <= 1'b1;
                        end else begin
                            word_q <= encode(bus.in_opcode, bus.in_rs, bus.in_rt,
                                             bus.in_rd, bus.in_imm);
                            byte_q <= 2'd0;
                        end
                    end
                end
                ST_WRITE: begin
                    byte_q <= byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        addr_q      <= addr_q + 13'd4;
                        instr_count <= instr_count + 32'd1;
                        if (word_q[31:26] inside {OP_BZ, OP_BEQ, OP_JR}) begin
                            branch_count <= branch_count + 32'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        addr_q       <= 13'(BASE_ADDR);
                        err_full     <= 1'b0;
                        instr_count  <= 32'd0;
                        branch_count <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
// Randomized bench for mips_program_loader against a byte-level memory-write reference model.
module tb_mips_program_loader;

    logic        clk = 1'b0;
    logic        reset, start, tb_valid, sel8;
    logic [5:0]  tb_op;
    logic [4:0]  tb_rs, tb_rt, tb_rd;
    logic [15:0] tb_imm;
    logic        busy, done, err_opcode, err_full;
    logic [31:0] instr_count, branch_count;
    logic        busy8, done8, err_opcode8, err_full8;
    logic [31:0] instr_count8, branch_count8;

    always #5 clk = ~clk;

    mips_program_loader_if bus();
    mips_program_loader_if bus8();

    assign bus.in_valid  = tb_valid && !sel8;
    assign bus8.in_valid = tb_valid && sel8;
    assign bus.in_opcode = tb_op;   assign bus8.in_opcode = tb_op;
    assign bus.in_rs     = tb_rs;   assign bus8.in_rs     = tb_rs;
    assign bus.in_rt     = tb_rt;   assign bus8.in_rt     = tb_rt;
    assign bus.in_rd     = tb_rd;   assign bus8.in_rd     = tb_rd;
    assign bus.in_imm    = tb_imm;  assign bus8.in_imm    = tb_imm;

    mips_program_loader #(.BASE_ADDR(0), .MEM_BYTES(4096)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .start(start),
        .busy(busy), .done(done), .err_opcode(err_opcode), .err_full(err_full),
        .instr_count(instr_count), .branch_count(branch_count)
    );

    mips_program_loader #(.BASE_ADDR(0), .MEM_BYTES(8)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8.slave), .start(start),
        .busy(busy8), .done(done8), .err_opcode(err_opcode8), .err_full(err_full8),
        .instr_count(instr_count8), .branch_count(branch_count8)
    );

    int checks = 0;
    int failures = 0;

    // Observed writes and the reference model's expected writes.
    logic [11:0] log_a[$];
    logic [7:0]  log_d[$];
    logic [11:0] log8_a[$];
    logic [7:0]  log8_d[$];
    int unsigned exp_a[$];
    logic [7:0]  exp_d[$];
    int m_addr, m_icnt, m_bcnt;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            log_a.push_back(bus.mem_addr);
            log_d.push_back(bus.mem_wdata);
        end
        if (bus8.mem_we === 1'b1) begin
            log8_a.push_back(bus8.mem_addr);
            log8_d.push_back(bus8.mem_wdata);
        end
    end

    function automatic int unsigned model_word(int op, int rs, int rt, int rd, int imm);
        int unsigned w;
        w = int'(op) * 67108864;
        if (op <= 10 && op % 2 == 0)
            w = w + rs * 2097152 + rt * 65536 + rd * 2048;
        else if (op <= 13 || op == 15)
            w = w + rs * 2097152 + rt * 65536 + (imm % 65536);
        else if (op == 14)
            w = w + rs * 2097152 + (imm % 65536);
        else if (op == 16)
            w = w + rs * 2097152;
        return w;
    endfunction

    task automatic model_send(int op, int rs, int rt, int rd, int imm);
        int unsigned w;
        if (op > 17) return;
        if (m_addr + 4 > 4096) return;
        w = model_word(op, rs, rt, rd, imm);
        for (int b = 0; b < 4; b++) begin
            exp_a.push_back(m_addr + b);
            exp_d.push_back(8'(w >> (24 - 8 * b)));
        end
        m_addr += 4;
        m_icnt++;
        if (op == 14 || op == 15 || op == 16) m_bcnt++;
    endtask

    task automatic model_reset();
        m_addr = 0; m_icnt = 0; m_bcnt = 0;
    endtask

    task automatic clear_logs();
        log_a.delete(); log_d.delete(); log8_a.delete(); log8_d.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    // Index of the first disagreement between observed and expected writes, -1 if none.
    function automatic int first_diff();
        if (log_a.size() != exp_a.size())
            return (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
        for (int i = 0; i < log_a.size(); i++)
            if (log_a[i] !== 12'(exp_a[i]) || log_d[i] !== exp_d[i]) return i;
        return -1;
    endfunction

    task automatic send(int op, int rs, int rt, int rd, int imm);
        tb_op = 6'(op); tb_rs = 5'(rs); tb_rt = 5'(rt); tb_rd = 5'(rd); tb_imm = 16'(imm);
        tb_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if ((sel8 ? bus8.in_ready : bus.in_ready) === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                tb_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tb_valid = 1'b0;
        checks++; failures++;
        $display("FAIL send_timeout in_ready=0 required=1");
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 32; k++) begin
            if (sel8 ? (bus8.in_ready === 1'b1 || done8 === 1'b1)
                     : (bus.in_ready === 1'b1 || done === 1'b1)) return;
            @(negedge clk);
        end
        checks++; failures++;
        $display("FAIL wait_idle_timeout loader never returned to IDLE/DONE");
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        tb_valid = 1'b0; start = 1'b0; reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        clear_logs();
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.mem_we !== 1'b0) begin
            failures++; $display("FAIL reset_ctl busy=%b done=%b we=%b required=000", busy, done, bus.mem_we); end
        checks++; if (err_opcode !== 1'b0 || err_full !== 1'b0) begin
            failures++; $display("FAIL reset_err err_opcode=%b err_full=%b required=00", err_opcode, err_full); end
        checks++; if (instr_count !== 32'd0 || branch_count !== 32'd0) begin
            failures++; $display("FAIL reset_counts instr=%0d branch=%0d required=0 0", instr_count, branch_count); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready in_ready=%b required=1", bus.in_ready); end
    endtask

    task automatic test_add();
        do_reset();
        model_send(0, 1, 2, 3, 0);
        send(0, 1, 2, 3, int'($urandom_range(0, 65535)));
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 12'd3) begin
            failures++; $display("FAIL add_last_byte busy=%b we=%b addr=%0d required=1 1 3", busy, bus.mem_we, bus.mem_addr); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL add_back_idle busy=%b ready=%b required=0 1", busy, bus.in_ready); end
        checks++; if (log_d.size() != 4 || {log_d[0], log_d[1], log_d[2], log_d[3]} !== 32'h00221800) begin
            failures++; $display("FAIL add_word bytes=%0d required word=00221800", log_d.size()); end
        checks++; if (first_diff() != -1) begin
            failures++; $display("FAIL add_log first bad entry=%0d required=-1", first_diff()); end
        checks++; if (instr_count !== 32'd1) begin
            failures++; $display("FAIL add_count instr=%0d required=1", instr_count); end
    endtask

    task automatic test_addi_beq();
        int rd1, rd2;
        do_reset();
        rd1 = int'($urandom_range(0, 31)); rd2 = int'($urandom_range(0, 31));
        model_send(1, 0, 1, rd1, 5);
        model_send(15, 1, 2, rd2, 16'hFFFE);
        send(1, 0, 1, rd1, 5);
        send(15, 1, 2, rd2, 16'hFFFE);
        wait_idle();
        checks++; if (log_d.size() != 8 || {log_d[0], log_d[1], log_d[2], log_d[3]} !== 32'h04010005
                      || {log_d[4], log_d[5], log_d[6], log_d[7]} !== 32'h3C22FFFE) begin
            failures++; $display("FAIL addi_beq_words bytes=%0d required 04010005 3C22FFFE", log_d.size()); end
        checks++; if (first_diff() != -1) begin
            failures++; $display("FAIL addi_beq_log first bad entry=%0d required=-1", first_diff()); end
        checks++; if (branch_count !== 32'd1 || instr_count !== 32'd2) begin
            failures++; $display("FAIL addi_beq_counts branch=%0d instr=%0d required=1 2", branch_count, instr_count); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        send(0, 1, 2, 3, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.mem_we !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_idle we=%b busy=%b ready=%b required=0 0 1", bus.mem_we, busy, bus.in_ready); end
        repeat (5) @(negedge clk);
        checks++; if (log_a.size() != 2 || log_a[0] !== 12'd0 || log_d[0] !== 8'h00
                      || log_a[1] !== 12'd1 || log_d[1] !== 8'h22) begin
            failures++; $display("FAIL midreset_bytes count=%0d required=2 (00@0 22@1)", log_a.size()); end
        model_reset(); clear_logs();
        model_send(0, 4, 5, 6, 0);
        send(0, 4, 5, 6, 0);
        wait_idle();
        checks++; if (first_diff() != -1) begin
            failures++; $display("FAIL midreset_addr0 first bad entry=%0d required=-1", first_diff()); end
    endtask

    task automatic test_bad_opcode();
        do_reset();
        send(20, int'($urandom_range(0, 31)), 3, 4, 77);
        checks++; if (err_opcode !== 1'b1 || bus.mem_we !== 1'b0) begin
            failures++; $display("FAIL badop_pulse err=%b we=%b required=1 0", err_opcode, bus.mem_we); end
        @(negedge clk);
        checks++; if (err_opcode !== 1'b0) begin
            failures++; $display("FAIL badop_once err=%b required=0", err_opcode); end
        model_send(0, 7, 8, 9, 0);
        send(0, 7, 8, 9, 0);
        wait_idle();
        checks++; if (first_diff() != -1 || instr_count !== 32'd1) begin
            failures++; $display("FAIL badop_next first bad entry=%0d instr=%0d required=-1 1", first_diff(), instr_count); end
    endtask

    task automatic test_halt();
        int rs, imm;
        do_reset();
        pulse_start();
        checks++; if (bus.in_ready !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL start_in_idle ready=%b done=%b required=1 0", bus.in_ready, done); end
        rs = int'($urandom_range(0, 31)); imm = int'($urandom_range(0, 65535));
        model_send(17, rs, 9, 31, imm);
        send(17, rs, 9, 31, imm);
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL halt_n4 done=%b busy=%b required=0 1", done, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || bus.in_ready !== 1'b0 || instr_count !== 32'd1) begin
            failures++; $display("FAIL halt_done done=%b ready=%b instr=%0d required=1 0 1", done, bus.in_ready, instr_count); end
        checks++; if (log_d.size() != 4 || {log_d[0], log_d[1], log_d[2], log_d[3]} !== 32'h44000000) begin
            failures++; $display("FAIL halt_word bytes=%0d required word=44000000", log_d.size()); end
        tb_op = 6'd0; tb_valid = 1'b1;
        repeat (4) @(negedge clk);
        tb_valid = 1'b0;
        checks++; if (first_diff() != -1 || done !== 1'b1) begin
            failures++; $display("FAIL done_ignores_valid first bad entry=%0d done=%b required=-1 1", first_diff(), done); end
        pulse_start();
        checks++; if (done !== 1'b0 || bus.in_ready !== 1'b1 || instr_count !== 32'd0) begin
            failures++; $display("FAIL restart done=%b ready=%b instr=%0d required=0 1 0", done, bus.in_ready, instr_count); end
        model_reset(); clear_logs();
        model_send(2, 3, 4, 5, 0);
        send(2, 3, 4, 5, 0);
        wait_idle();
        checks++; if (first_diff() != -1) begin
            failures++; $display("FAIL restart_base first bad entry=%0d required=-1", first_diff()); end
    endtask

    task automatic test_back_to_back();
        int op, rs, rt, rd, imm;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 20)); rs = int'($urandom_range(0, 31));
            rt = int'($urandom_range(0, 31)); rd = int'($urandom_range(0, 31));
            imm = int'($urandom_range(0, 65535));
            model_send(op, rs, rt, rd, imm);
            send(op, rs, rt, rd, imm);
            checks++; if (err_opcode !== (op > 17)) begin
                failures++; $display("FAIL rand_err op=%0d err=%b required=%b", op, err_opcode, op > 17); end
            if (op == 17) begin
                wait_idle();
                pulse_start();
                model_reset();
            end
        end
        wait_idle();
        checks++; if (first_diff() != -1) begin
            failures++; $display("FAIL rand_log first bad entry=%0d required=-1", first_diff()); end
        checks++; if (instr_count !== 32'(m_icnt) || branch_count !== 32'(m_bcnt)) begin
            failures++; $display("FAIL rand_counts instr=%0d branch=%0d required=%0d %0d",
                                 instr_count, branch_count, m_icnt, m_bcnt); end
    endtask

    task automatic test_full();
        int hits8;
        do_reset();
        sel8 = 1'b1;
        send(0, 1, 2, 3, 0);
        send(6, 4, 5, 6, 0);
        send(1, 7, 8, 9, 10);
        wait_idle();
        repeat (2) @(negedge clk);
        hits8 = 0;
        foreach (log8_a[i]) if (log8_a[i] >= 12'd8) hits8++;
        checks++; if (err_full8 !== 1'b1 || done8 !== 1'b1) begin
            failures++; $display("FAIL full_flag err_full=%b done=%b required=1 1", err_full8, done8); end
        checks++; if (log8_a.size() != 8 || hits8 != 0 || instr_count8 !== 32'd2) begin
            failures++; $display("FAIL full_writes bytes=%0d beyond=%0d instr=%0d required=8 0 2",
                                 log8_a.size(), hits8, instr_count8); end
        sel8 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tb_valid = 1'b0; sel8 = 1'b0;
        tb_op = '0; tb_rs = '0; tb_rt = '0; tb_rd = '0; tb_imm = '0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_add();
        test_addi_beq();
        test_reset_mid_write();
        test_bad_opcode();
        test_halt();
        test_back_to_back();
        test_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
